// File: rtl/usb_tx_pkg.sv
// Shared types and defaults for the USB transmit-path arbiter.
package usb_tx_pkg;

   localparam int TX_DATA_W      = 64;
   localparam int TX_NUM_REQ_DEF = 4;
   localparam int TX_TIMEOUT_DEF = 1024;

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      LOAD,
      START,
      WAIT_ACK,
      COMPLETE,
      ABORT,
      DRAIN
   } tx_state_e;

endpackage

// File: rtl/usb_tx_arbiter_pick.sv
// rr_arbiter_pick: combinational round-robin search starting at ptr.
module rr_arbiter_pick
   import usb_tx_pkg::*;
#(
   parameter int NUM_REQ = TX_NUM_REQ_DEF,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   winner,
   output logic               valid
);

   // Walk the offsets from farthest to nearest so the nearest hit to ptr is kept.
   always_comb begin
      winner = ptr;
      valid  = |req;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % NUM_REQ]) begin
            winner = IDX_W'((int'(ptr) + k) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: round-robin owner of the shared USB transmit path (tcu, shift regs, CRC).
// Packet/timeout counters exist only when TX_ARB_STATS_EN is defined.
module usb_tx_arbiter
   import usb_tx_pkg::*;
#(
   parameter int NUM_REQ        = TX_NUM_REQ_DEF,
   parameter int TIMEOUT_CYCLES = TX_TIMEOUT_DEF,
   parameter int DATA_W         = TX_DATA_W
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        done,
   output logic [NUM_REQ-1:0]        err,
   output logic                      busy,
   output logic [DATA_W-1:0]         trans_data,
   output logic                      trans_data_ready,
   input  logic                      handshake_ack,
   input  logic                      idle_transmitting,
   output logic [2:0]                dbg_state
`ifdef TX_ARB_STATS_EN
   ,
   output logic [15:0]               pkt_count,
   output logic [15:0]               timeout_count
`endif
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

   tx_state_e          state;
   tx_state_e          state_nxt;
   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   winner;
   logic [IDX_W-1:0]   pick;
   logic               pick_valid;
   logic [CNT_W-1:0]   cnt;
   logic [NUM_REQ-1:0] owner;
   logic               owns;

   rr_arbiter_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req    (req),
      .ptr    (ptr),
      .winner (pick),
      .valid  (pick_valid)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if ((|req) && idle_transmitting) state_nxt = ARB;
         ARB:      state_nxt = pick_valid ? LOAD : IDLE;
         LOAD:     state_nxt = START;
         START:    state_nxt = WAIT_ACK;
         WAIT_ACK: begin
            // An ack landing on the last counted cycle still completes the packet.
            if (handshake_ack)        state_nxt = COMPLETE;
            else if (cnt == CNT_LAST) state_nxt = ABORT;
         end
         COMPLETE: state_nxt = IDLE;
         ABORT:    state_nxt = DRAIN;
         DRAIN:    if (idle_transmitting) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      owner            = '0;
      owner[winner]    = 1'b1;
      owns             = (state == LOAD) || (state == START) || (state == WAIT_ACK) ||
                         (state == COMPLETE) || (state == ABORT);
      grant            = owns ? owner : '0;
      done             = (state == COMPLETE) ? owner : '0;
      err              = (state == ABORT) ? owner : '0;
      busy             = (state != IDLE);
      trans_data_ready = (state == START);
      dbg_state        = state;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= IDLE;
         ptr        <= '0;
         winner     <= '0;
         cnt        <= '0;
         trans_data <= '0;
      end else begin
         state <= state_nxt;
         if (state == ARB && pick_valid) winner <= pick;
         if (state == LOAD) trans_data <= req_data[int'(winner)*DATA_W +: DATA_W];
         if (state == START)         cnt <= '0;
         else if (state == WAIT_ACK) cnt <= cnt + 1'b1;
         // The served requester drops to lowest priority for the next round.
         if (state == COMPLETE || state == ABORT) begin
            ptr <= (winner == IDX_LAST) ? '0 : winner + 1'b1;
         end
      end
   end

`ifdef TX_ARB_STATS_EN
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pkt_count     <= '0;
         timeout_count <= '0;
      end else begin
         if (state == COMPLETE && pkt_count != 16'hFFFF)  pkt_count     <= pkt_count + 16'd1;
         if (state == ABORT && timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Bench for usb_tx_arbiter: directed scenarios plus random traffic against a transaction-timeline model.
// Build with TX_ARB_STATS_EN defined to also check the packet/timeout counters.
module tb_usb_tx_arbiter;

  localparam int N   = 4;
  localparam int W   = 64;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           n_rst = 1'b0;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   grant, done, err;
  logic           busy, trans_data_ready;
  logic [W-1:0]   trans_data;
  logic           handshake_ack, idle_transmitting;
  logic [2:0]     dbg_state;
`ifdef TX_ARB_STATS_EN
  logic [15:0]    pkt_count, timeout_count;
`endif

  usb_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO), .DATA_W(W)) dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .req               (req),
    .req_data          (req_data),
    .grant             (grant),
    .done              (done),
    .err               (err),
    .busy              (busy),
    .trans_data        (trans_data),
    .trans_data_ready  (trans_data_ready),
    .handshake_ack     (handshake_ack),
    .idle_transmitting (idle_transmitting),
    .dbg_state         (dbg_state)
`ifdef TX_ARB_STATS_EN
    ,
    .pkt_count         (pkt_count),
    .timeout_count     (timeout_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // tcu model: acks k cycles after the strobe (k=0: never), holds the line busy meanwhile
  bit tcu_rand  = 1'b0;
  int tcu_delay = 12;
  int tcu_noack = 30;

  initial begin
    int k;
    handshake_ack     = 1'b0;
    idle_transmitting = 1'b1;
    forever begin
      @(negedge clk);
      if (n_rst === 1'b1 && trans_data_ready === 1'b1) begin
        k = tcu_rand ? int'($urandom_range(0, 20)) : tcu_delay;
        idle_transmitting = 1'b0;
        if (k > 0) begin
          repeat (k) @(posedge clk);
          #1 handshake_ack = 1'b1;
          @(posedge clk);
          #1 handshake_ack = 1'b0;
        end else begin
          repeat (tcu_rand ? int'($urandom_range(10, 25)) : tcu_noack) @(posedge clk);
        end
        repeat (tcu_rand ? int'($urandom_range(0, 3)) : 1) @(posedge clk);
        #1 idle_transmitting = 1'b1;
      end else if (tcu_rand && n_rst === 1'b1 && $urandom_range(0, 15) == 0) begin
        idle_transmitting = 1'b0;
        @(posedge clk);
        #1 idle_transmitting = 1'b1;
      end
    end
  end

  // reference model: a per-transaction timeline driven from the rules of the arbiter
  logic [N-1:0] exp_grant, exp_done, exp_err;
  logic         exp_busy, exp_tdr;
  logic [W-1:0] exp_data;
  int           m_ptr, m_pkt, m_tmo;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_run();
    int w;
    int n;
    bit acked;
    forever begin
      @(posedge clk); if (n_rst !== 1'b1) return;
      if (!((|req) && idle_transmitting)) continue;
      exp_busy = 1'b1;
      @(posedge clk); if (n_rst !== 1'b1) return;
      w = rr_pick(req, m_ptr);
      if (w < 0) begin
        exp_busy = 1'b0;
        continue;
      end
      exp_grant = '0;
      exp_grant[w] = 1'b1;
      @(posedge clk); if (n_rst !== 1'b1) return;
      exp_data = req_data[w*W +: W];
      exp_tdr  = 1'b1;
      @(posedge clk); if (n_rst !== 1'b1) return;
      exp_tdr = 1'b0;
      n = 0;
      acked = 1'b0;
      forever begin
        @(posedge clk); if (n_rst !== 1'b1) return;
        if (handshake_ack) begin acked = 1'b1; break; end
        if (n == TMO - 1) break;
        n++;
      end
      if (acked) exp_done = exp_grant;
      else       exp_err  = exp_grant;
      m_ptr = (w + 1) % N;
      @(posedge clk); if (n_rst !== 1'b1) return;
      if (acked) begin if (m_pkt < 65535) m_pkt++; end
      else       begin if (m_tmo < 65535) m_tmo++; end
      exp_done  = '0;
      exp_err   = '0;
      exp_grant = '0;
      if (!acked) begin
        forever begin
          @(posedge clk); if (n_rst !== 1'b1) return;
          if (idle_transmitting) break;
        end
      end
      exp_busy = 1'b0;
    end
  endtask

  initial begin
    forever begin
      exp_grant = '0; exp_done = '0; exp_err = '0;
      exp_busy  = 1'b0; exp_tdr = 1'b0; exp_data = '0;
      m_ptr = 0; m_pkt = 0; m_tmo = 0;
      wait (n_rst === 1'b1);
      model_run();
    end
  end

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clk) begin
    if (n_rst !== 1'b1) begin
      chk("rst_grant", grant, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tdr", trans_data_ready, 0);
      chk("rst_data", trans_data, 0);
    end else begin
      chk("grant", grant, exp_grant);
      chk("done", done, exp_done);
      chk("err", err, exp_err);
      chk("busy", busy, exp_busy);
      chk("tdr", trans_data_ready, exp_tdr);
      chk("trans_data", trans_data, exp_data);
`ifdef TX_ARB_STATS_EN
      chk("pkt_count", pkt_count, 16'(m_pkt));
      chk("timeout_count", timeout_count, 16'(m_tmo));
`endif
    end
  end

  // driver helpers
  task automatic fail_bound(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s actual=expired required=event t=%0t", name, $time);
  endtask

  task automatic wait_strobe(output int cyc, output logic [N-1:0] g, output logic [W-1:0] d);
    cyc = 0; g = '0; d = '0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (trans_data_ready === 1'b1) begin
        g = grant;
        d = trans_data;
        return;
      end
    end
    fail_bound("strobe_wait");
  endtask

  task automatic wait_end(output int cyc, output logic [N-1:0] dn, output logic [N-1:0] er);
    cyc = 0; dn = '0; er = '0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if ((|done) || (|err)) begin
        dn = done;
        er = err;
        return;
      end
    end
    fail_bound("end_wait");
  endtask

  task automatic wait_free();
    int c;
    c = 0;
    while (c < 300) begin
      @(negedge clk);
      c++;
      if (busy === 1'b0 && idle_transmitting === 1'b1) begin
        step();
        return;
      end
    end
    fail_bound("free_wait");
  endtask

  task automatic one_txn(input logic [N-1:0] m, output logic [N-1:0] dn, output logic [N-1:0] er);
    int cc;
    logic [N-1:0] gg;
    logic [W-1:0] dd;
    req = m;
    wait_strobe(cc, gg, dd);
    wait_end(cc, dn, er);
    step();
    req = '0;
    wait_free();
  endtask

  task automatic random_phase(input int cycles);
    logic [N-1:0] fin;
    tcu_rand = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      fin = done | err;
      step();
      for (int i = 0; i < N; i++) begin
        if (fin[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else req_data[i*W +: W] = {$urandom, $urandom};
        end else if (!req[i] && $urandom_range(0, 7) == 0) begin
          req_data[i*W +: W] = {$urandom, $urandom};
          req[i] = 1'b1;
        end
      end
    end
    tcu_rand = 1'b0;
  endtask

  int           c, hits;
  logic [N-1:0] g, dn, er, oh;
  logic [W-1:0] d;
  int           t2_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    req = '0;
    req_data = '0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    chk("reset_grant", grant, 0);
    chk("reset_busy", busy, 0);
    chk("reset_data", trans_data, 0);

    // two requesters, served in index order from ptr 0
    step();
    req_data[0*W +: W] = 64'h1111;
    req_data[2*W +: W] = 64'h2222;
    req = 4'b0101;
    wait_strobe(c, g, d);
    chk("t1_latency", c - 1, 3);
    chk("t1_grant0", g, 4'b0001);
    chk("t1_data0", d, 64'h1111);
    wait_end(c, dn, er);
    chk("t1_done0", dn, 4'b0001);
    chk("t1_err0", er, 0);
    step();
    req[0] = 1'b0;
    wait_strobe(c, g, d);
    chk("t1_grant2", g, 4'b0100);
    chk("t1_data2", d, 64'h2222);
    wait_end(c, dn, er);
    chk("t1_done2", dn, 4'b0100);
    step();
    req = 4'b1111;
    wait_strobe(c, g, d);
    chk("t1_ptr3", g, 4'b1000);

    // reset in the middle of WAIT_ACK
    repeat (5) step();
    #2 n_rst = 1'b0;
    #1;
    chk("t5_grant", grant, 0);
    chk("t5_busy", busy, 0);
    chk("t5_tdr", trans_data_ready, 0);
    chk("t5_data", trans_data, 0);
    step();
    step();
    req = '0;
    n_rst = 1'b1;
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      if ((|done) || (|err)) hits++;
    end
    chk("t5_no_done_err", hits, 0);
    wait_free();

    // all four held: strict rotation
    tcu_delay = 10;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 64'hA0 + 64'(i);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_strobe(c, g, d);
      oh = '0;
      oh[t2_exp[i]] = 1'b1;
      chk("t2_grant", g, oh);
      chk("t2_data", d, 64'hA0 + 64'(t2_exp[i]));
      wait_end(c, dn, er);
      chk("t2_done", dn, oh);
    end
    step();
    req = '0;
    wait_free();

    // no ack: abort after TMO+1 cycles, drain until the line is idle
    tcu_delay = 0;
    tcu_noack = 30;
    req = 4'b0010;
    wait_strobe(c, g, d);
    chk("t3_grant", g, 4'b0010);
    wait_end(c, dn, er);
    chk("t3_err_cycle", c, TMO + 1);
    chk("t3_err", er, 4'b0010);
    chk("t3_no_done", dn, 0);
    step();
    req = '0;
    @(negedge clk);
    chk("t3_drain_busy", busy, 1);
    c = 0;
    while (busy === 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("t3_free_busy", busy, 0);
    chk("t3_free_idle", idle_transmitting, 1);
    wait_free();

    // ack on the last counted cycle wins over timeout
    tcu_delay = TMO;
    req = 4'b0001;
    wait_strobe(c, g, d);
    wait_end(c, dn, er);
    chk("t4_end_cycle", c, TMO + 1);
    chk("t4_done", dn, 4'b0001);
    chk("t4_no_err", er, 0);
    step();
    req = '0;
    wait_free();

    // request withdrawn during ARB: no grant
    req = 4'b0100;
    step();
    req = '0;
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (trans_data_ready === 1'b1) hits++;
    end
    chk("t6_no_strobe", hits, 0);
    chk("t6_idle", busy, 0);

    // request withdrawn after capture: packet still completes
    step();
    tcu_delay = 6;
    req_data[2*W +: W] = 64'hDEAD_BEEF_0123_4567;
    req = 4'b0100;
    wait_strobe(c, g, d);
    step();
    req = '0;
    chk("t7_data", d, 64'hDEAD_BEEF_0123_4567);
    wait_end(c, dn, er);
    chk("t7_done", dn, 4'b0100);
    wait_free();

    // counters: three acked, one timed out, from a fresh reset
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    step();
    tcu_delay = 5;
    one_txn(4'b0001, dn, er);
    chk("s_done0", dn, 4'b0001);
    one_txn(4'b0010, dn, er);
    chk("s_done1", dn, 4'b0010);
    one_txn(4'b0100, dn, er);
    chk("s_done2", dn, 4'b0100);
    tcu_delay = 0;
    tcu_noack = 20;
    one_txn(4'b1000, dn, er);
    chk("s_err3", er, 4'b1000);
`ifdef TX_ARB_STATS_EN
    chk("s_pkt_count", pkt_count, 3);
    chk("s_timeout_count", timeout_count, 1);
`endif

    random_phase(3000);
    req = '0;
    wait_free();
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
